// File: rtl/rah_app_arbiter.sv
// Round-robin arbiter that shares the RAH encoder write port between app lanes.
// Each grant carries a bounded burst, and the encoder's programmable-full stalls it with zero latency.
module rah_app_arbiter #(
    parameter int unsigned TOTAL_APPS = 2,
    parameter int unsigned DATA_WIDTH = 48,
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned ID_WIDTH   = (TOTAL_APPS > 1) ? $clog2(TOTAL_APPS) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [TOTAL_APPS-1:0]            req_valid,
    input  logic [TOTAL_APPS*DATA_WIDTH-1:0] req_data,
    input  logic [TOTAL_APPS-1:0]            req_last,
    output logic [TOTAL_APPS-1:0]            req_ready,
    input  logic                             out_full,
    output logic                             out_valid,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [ID_WIDTH-1:0]              out_app_id,
    output logic                             out_last,
    output logic                             busy
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_e;

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]   grant_idx_q, grant_idx_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ID_WIDTH-1:0]   out_app_id_q, out_app_id_d;
    logic                  out_last_q, out_last_d;

    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  lo_found, hi_found;
    logic [ID_WIDTH-1:0]   lo_pick, hi_pick, pick;
    logic                  xfer;
    logic                  burst_end;

    // Lane mux for the current owner
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < TOTAL_APPS; i++) begin
            if (grant_idx_q == ID_WIDTH'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // First requester at or after rr_ptr; fall back to the lowest requester to wrap
    always_comb begin
        lo_found = 1'b0;
        hi_found = 1'b0;
        lo_pick  = '0;
        hi_pick  = '0;
        for (int unsigned i = 0; i < TOTAL_APPS; i++) begin
            if (req_valid[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_pick  = ID_WIDTH'(i);
            end
            if (req_valid[i] && !hi_found && (i >= 32'(rr_ptr_q))) begin
                hi_found = 1'b1;
                hi_pick  = ID_WIDTH'(i);
            end
        end
        pick = hi_found ? hi_pick : lo_pick;
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_idx_d  = grant_idx_q;
        beat_cnt_d   = beat_cnt_q;
        req_ready    = '0;
        xfer         = 1'b0;
        burst_end    = 1'b0;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        out_app_id_d = out_app_id_q;
        out_last_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    grant_idx_d = pick;
                    beat_cnt_d  = '0;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Ready follows out_full combinationally so a full edge blocks that same edge
                for (int unsigned i = 0; i < TOTAL_APPS; i++) begin
                    if (grant_idx_q == ID_WIDTH'(i)) begin
                        req_ready[i] = ~out_full;
                    end
                end
                xfer = sel_valid & ~out_full;
                if (xfer) begin
                    beat_cnt_d   = beat_cnt_q + CNT_W'(1);
                    burst_end    = sel_last | (beat_cnt_q + CNT_W'(1) == CNT_W'(MAX_BURST));
                    out_valid_d  = 1'b1;
                    out_data_d   = sel_data;
                    out_app_id_d = grant_idx_q;
                    out_last_d   = burst_end;
                    if (burst_end) begin
                        rr_ptr_d = (grant_idx_q == ID_WIDTH'(TOTAL_APPS - 1)) ?
                                   '0 : grant_idx_q + ID_WIDTH'(1);
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            grant_idx_q  <= '0;
            beat_cnt_q   <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_app_id_q <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_idx_q  <= grant_idx_d;
            beat_cnt_q   <= beat_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_app_id_q <= out_app_id_d;
            out_last_q   <= out_last_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_app_id = out_app_id_q;
    assign out_last   = out_last_q;
    assign busy       = (state_q == ST_GRANT);

endmodule

// File: tb/tb_rah_app_arbiter.sv
// Scoreboard bench for rah_app_arbiter with two apps and MAX_BURST=4.
// App lane drivers feed beats, expected beats are queued per test, and a monitor compares them at negedge.
module tb_rah_app_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned DW = 48;
    localparam int unsigned MB = 4;
    localparam int unsigned IW = 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            out_full;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_app_id;
    logic            out_last;
    logic            busy;

    beat_t q0[$];
    beat_t q1[$];
    exp_t  exp_q[$];
    exp_t  mon_e;
    logic  en0 = 1'b1;
    logic  en1 = 1'b1;
    logic  full = 1'b0;
    int    vectors = 0;
    int    miscompares = 0;

    rah_app_arbiter #(
        .TOTAL_APPS(N),
        .DATA_WIDTH(DW),
        .MAX_BURST (MB),
        .ID_WIDTH  (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_full  (out_full),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_app_id(out_app_id),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic drive();
        req_valid[0]        = en0 && (q0.size() > 0);
        req_data[0 +: DW]   = (q0.size() > 0) ? q0[0].data : '0;
        req_last[0]         = (q0.size() > 0) ? q0[0].last : 1'b0;
        req_valid[1]        = en1 && (q1.size() > 0);
        req_data[DW +: DW]  = (q1.size() > 0) ? q1[0].data : '0;
        req_last[1]         = (q1.size() > 0) ? q1[0].last : 1'b0;
        out_full            = full;
    endtask

    task automatic push_beat(input int app, input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        if (app == 0) q0.push_back(b);
        else          q1.push_back(b);
    endtask

    task automatic expect_beat(input int id, input logic [DW-1:0] d, input logic l);
        exp_t e;
        e.id   = IW'(id);
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    // One clock: handshakes are judged mid-cycle, then lanes advance after the edge
    task automatic run_cycle();
        logic [N-1:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        if (hs[0]) void'(q0.pop_front());
        if (hs[1]) void'(q1.pop_front());
        drive();
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        int left;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0) && n < budget) begin
            run_cycle();
            n++;
        end
        left = q0.size() + q1.size() + exp_q.size();
        check(name, 64'(left), 64'(0));
        q0.delete();
        q1.delete();
        exp_q.delete();
        drive();
    endtask

    task automatic run_until_q(input int app, input int sz, input string name);
        int n;
        n = 0;
        while (((app == 0) ? q0.size() : q1.size()) != sz && n < 50) begin
            run_cycle();
            n++;
        end
        check(name, 64'((app == 0) ? q0.size() : q1.size()), 64'(sz));
    endtask

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_beat: got id=%0d data=%0h last=%0b expected none",
                             out_app_id, out_data, out_last);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (out_app_id !== mon_e.id || out_data !== mon_e.data || out_last !== mon_e.last) begin
                        miscompares++;
                        $display("FAIL beat: got id=%0d data=%0h last=%0b expected id=%0d data=%0h last=%0b",
                                 out_app_id, out_data, out_last, mon_e.id, mon_e.data, mon_e.last);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid",  64'(out_valid),  64'(0));
        check("rst_out_data",   64'(out_data),   64'(0));
        check("rst_out_app_id", 64'(out_app_id), 64'(0));
        check("rst_out_last",   64'(out_last),   64'(0));
        check("rst_busy",       64'(busy),       64'(0));
        check("rst_req_ready",  64'(req_ready),  64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester
        push_beat(1, 48'hA1, 1'b0);
        push_beat(1, 48'hA2, 1'b0);
        push_beat(1, 48'hA3, 1'b1);
        expect_beat(1, 48'hA1, 1'b0);
        expect_beat(1, 48'hA2, 1'b0);
        expect_beat(1, 48'hA3, 1'b1);
        drive();
        wait_done("single_done", 40);
        check("single_idle", 64'(busy), 64'(0));

        // Round robin, two-beat packets
        for (int p = 0; p < 2; p++) begin
            push_beat(0, 48'hB0 + 48'(2*p),     1'b0);
            push_beat(0, 48'hB0 + 48'(2*p + 1), 1'b1);
            push_beat(1, 48'hC0 + 48'(2*p),     1'b0);
            push_beat(1, 48'hC0 + 48'(2*p + 1), 1'b1);
        end
        expect_beat(0, 48'hB0, 1'b0); expect_beat(0, 48'hB1, 1'b1);
        expect_beat(1, 48'hC0, 1'b0); expect_beat(1, 48'hC1, 1'b1);
        expect_beat(0, 48'hB2, 1'b0); expect_beat(0, 48'hB3, 1'b1);
        expect_beat(1, 48'hC2, 1'b0); expect_beat(1, 48'hC3, 1'b1);
        drive();
        wait_done("rr_done", 60);

        // Burst limit splits a 10-beat packet
        for (int b = 0; b < 10; b++) push_beat(0, 48'hD0 + 48'(b), (b == 9));
        push_beat(1, 48'hE0, 1'b0);
        push_beat(1, 48'hE1, 1'b1);
        for (int b = 0; b < 4; b++) expect_beat(0, 48'hD0 + 48'(b), (b == 3));
        expect_beat(1, 48'hE0, 1'b0);
        expect_beat(1, 48'hE1, 1'b1);
        for (int b = 4; b < 8; b++) expect_beat(0, 48'hD0 + 48'(b), (b == 7));
        expect_beat(0, 48'hD8, 1'b0);
        expect_beat(0, 48'hD9, 1'b1);
        drive();
        wait_done("burst_done", 80);

        // Back-pressure mid-burst
        for (int b = 0; b < 4; b++) begin
            push_beat(1, 48'hF0 + 48'(b), (b == 3));
            expect_beat(1, 48'hF0 + 48'(b), (b == 3));
        end
        drive();
        run_until_q(1, 2, "bp_reach");
        full = 1'b1;
        drive();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_ready", 64'(req_ready), 64'(0));
            if (c > 0) check("bp_valid", 64'(out_valid), 64'(0));
            @(posedge clk);
            #1;
        end
        full = 1'b0;
        drive();
        wait_done("bp_done", 40);

        // Owner stall holds the grant
        for (int b = 0; b < 4; b++) begin
            push_beat(0, 48'h60 + 48'(b), (b == 3));
            expect_beat(0, 48'h60 + 48'(b), (b == 3));
        end
        push_beat(1, 48'h70, 1'b0);
        push_beat(1, 48'h71, 1'b1);
        expect_beat(1, 48'h70, 1'b0);
        expect_beat(1, 48'h71, 1'b1);
        drive();
        run_until_q(0, 2, "stall_reach");
        en0 = 1'b0;
        drive();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_busy",  64'(busy),         64'(1));
            check("stall_other", 64'(req_ready[1]), 64'(0));
            if (c > 0) check("stall_valid", 64'(out_valid), 64'(0));
            @(posedge clk);
            #1;
        end
        en0 = 1'b1;
        drive();
        wait_done("stall_done", 40);

        // Move rr_ptr to 1, then reset in the middle of app 1's burst
        push_beat(0, 48'h80, 1'b1);
        expect_beat(0, 48'h80, 1'b1);
        drive();
        wait_done("pre_rst_done", 20);
        push_beat(1, 48'h90, 1'b0);
        push_beat(1, 48'h91, 1'b0);
        push_beat(1, 48'h92, 1'b1);
        expect_beat(1, 48'h90, 1'b0);
        drive();
        run_until_q(1, 2, "arst_reach");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'(0));
        check("arst_req_ready", 64'(req_ready), 64'(0));
        check("arst_busy",      64'(busy),      64'(0));
        check("arst_scoreboard", 64'(exp_q.size()), 64'(0));
        q1.delete();
        exp_q.delete();
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        push_beat(0, 48'hB5, 1'b1);
        push_beat(1, 48'hC5, 1'b1);
        expect_beat(0, 48'hB5, 1'b1);
        expect_beat(1, 48'hC5, 1'b1);
        drive();
        wait_done("post_rst_done", 30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
